vga3_interface: RTL



---
 rtl/vga3_interface_pkg.sv | 31 +++
 rtl/vga3_interface_if.sv | 32 +++
 rtl/vga3_axis_counter.sv | 53 +++++
 rtl/vga3_interface.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/vga3_interface_pkg.sv
// Shared region encodings, pipeline flag positions and axis helpers for the
// vga3_interface timing and pixel pipeline.
package vga3_interface_pkg;

    typedef enum logic [1:0] {
        RegionVisible = 2'd0,
        RegionFront   = 2'd1,
        RegionSync    = 2'd2,
        RegionBack    = 2'd3
    } region_e;

    // Bit positions inside the alignment pipeline flag vector
    localparam int unsigned FlagVisible = 0;
    localparam int unsigned FlagHsync   = 1;
    localparam int unsigned FlagVsync   = 2;
    localparam int unsigned FlagBorder  = 3;

    function automatic int unsigned axis_total(input int unsigned vis, input int unsigned fp,
                                               input int unsigned sp, input int unsigned bp);
        return vis + fp + sp + bp;
    endfunction

    function automatic region_e axis_region(input int unsigned pos, input int unsigned vis,
                                            input int unsigned fp, input int unsigned sp);
        if (pos < vis) return RegionVisible;
        if (pos < vis + fp) return RegionFront;
        if (pos < vis + fp + sp) return RegionSync;
        return RegionBack;
    endfunction

endpackage

// File: rtl/vga3_interface_if.sv
// Framebuffer-side and VGA-pin-side signals of vga3_interface. The master
// modport is the timing/pixel stage, the slave modport is its environment.
interface vga3_interface_if #(
    parameter int unsigned HAddrSize  = 11,
    parameter int unsigned VAddrSize  = 11,
    parameter int unsigned ColorWidth = 4
);
    logic [ColorWidth-1:0] color_r;
    logic [ColorWidth-1:0] color_g;
    logic [ColorWidth-1:0] color_b;
    logic [HAddrSize-1:0]  fb_addr_h;
    logic [VAddrSize-1:0]  fb_addr_v;
    logic                  fb_read;
    logic                  frame_start;
    logic                  vga_hsync;
    logic                  vga_vsync;
    logic [ColorWidth-1:0] vga_r;
    logic [ColorWidth-1:0] vga_g;
    logic [ColorWidth-1:0] vga_b;

    modport master (
        input  color_r, color_g, color_b,
        output fb_addr_h, fb_addr_v, fb_read, frame_start,
        output vga_hsync, vga_vsync, vga_r, vga_g, vga_b
    );

    modport slave (
        output color_r, color_g, color_b,
        input  fb_addr_h, fb_addr_v, fb_read, frame_start,
        input  vga_hsync, vga_vsync, vga_r, vga_g, vga_b
    );
endinterface

// File: rtl/vga3_axis_counter.sv
// One timing axis: position counter with wrap, plus visible/sync region flags.
module vga3_axis_counter
    import vga3_interface_pkg::*;
#(
    parameter int unsigned Width      = 11,
    parameter int unsigned Visible    = 640,
    parameter int unsigned FrontPorch = 16,
    parameter int unsigned SyncPulse  = 96,
    parameter int unsigned BackPorch  = 48
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    output logic [Width-1:0] count,
    output logic             wrap,
    output logic             visible,
    output logic             sync_active
);
    localparam int unsigned Total = axis_total(Visible, FrontPorch, SyncPulse, BackPorch);
    localparam logic [Width-1:0] Last = Width'(Total - 1);

    if (64'(Total - 1) >= (64'd1 << Width)) begin : g_width_check
        $error("vga3_axis_counter: Width cannot hold Total-1");
    end

    logic [Width-1:0] count_q, count_d;
    region_e          region;

    always_comb begin
        wrap    = enable && (count_q == Last);
        count_d = count_q;
        if (enable) begin
            count_d = wrap ? '0 : count_q + Width'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_comb begin
        region      = axis_region(32'(count_q), Visible, FrontPorch, SyncPulse);
        visible     = (region == RegionVisible);
        sync_active = (region == RegionSync);
    end

    assign count = count_q;

endmodule

// File: rtl/vga3_interface.sv
// VGA timing generator and pixel output stage with framebuffer-latency alignment.
// Define VGA3_INTERFACE_BORDER_EN to overlay BorderColor on the visible frame edge.
module vga3_interface
    import vga3_interface_pkg::*;
#(
    parameter int unsigned HAddrSize     = 11,
    parameter int unsigned HVisibleArea  = 640,
    parameter int unsigned HFrontPorch   = 16,
    parameter int unsigned HSyncPulse    = 96,
    parameter int unsigned HBackPorch    = 48,
    parameter int unsigned VAddrSize     = 11,
    parameter int unsigned VVisibleArea  = 480,
    parameter int unsigned VFrontPorch   = 10,
    parameter int unsigned VSyncPulse    = 2,
    parameter int unsigned VBackPorch    = 33,
    parameter int unsigned ColorWidth    = 4,
    parameter int unsigned ClockDivide   = 1,
    parameter int unsigned FbLatency     = 1,
    parameter bit          HSyncPolarity = 1'b0,
    parameter bit          VSyncPolarity = 1'b0
`ifdef VGA3_INTERFACE_BORDER_EN
    ,
    parameter logic [3*ColorWidth-1:0] BorderColor = '1
`endif
) (
    input logic              clock,
    input logic              reset,
    vga3_interface_if.master vga
);
`ifdef VGA3_INTERFACE_BORDER_EN
    localparam int unsigned FlagWidth = 4;
`else
    localparam int unsigned FlagWidth = 3;
`endif
    localparam int unsigned DivWidth = (ClockDivide > 1) ? $clog2(ClockDivide) : 1;
    localparam logic [DivWidth-1:0] DivLast = DivWidth'(ClockDivide - 1);

    if (ClockDivide < 1) begin : g_divide_check
        $error("vga3_interface: ClockDivide must be at least 1");
    end

    // Pixel prescaler
    logic [DivWidth-1:0] div_q, div_d;
    logic                tick;

    always_comb begin
        tick  = (div_q == DivLast);
        div_d = tick ? '0 : div_q + DivWidth'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    logic [HAddrSize-1:0] h_count;
    logic [VAddrSize-1:0] v_count;
    logic h_wrap, h_visible, h_sync_active;
    logic unused_v_wrap, v_visible, v_sync_active;

    vga3_axis_counter #(
        .Width      (HAddrSize),
        .Visible    (HVisibleArea),
        .FrontPorch (HFrontPorch),
        .SyncPulse  (HSyncPulse),
        .BackPorch  (HBackPorch)
    ) u_h_counter (
        .clock       (clock),
        .reset       (reset),
        .enable      (tick),
        .count       (h_count),
        .wrap        (h_wrap),
        .visible     (h_visible),
        .sync_active (h_sync_active)
    );

    vga3_axis_counter #(
        .Width      (VAddrSize),
        .Visible    (VVisibleArea),
        .FrontPorch (VFrontPorch),
        .SyncPulse  (VSyncPulse),
        .BackPorch  (VBackPorch)
    ) u_v_counter (
        .clock       (clock),
        .reset       (reset),
        .enable      (h_wrap),
        .count       (v_count),
        .wrap        (unused_v_wrap),
        .visible     (v_visible),
        .sync_active (v_sync_active)
    );

    // Counters already read zero while reset is held; keep the strobes quiet then
    assign vga.fb_addr_h   = h_count;
    assign vga.fb_addr_v   = v_count;
    assign vga.fb_read     = ~reset & tick & h_visible & v_visible;
    assign vga.frame_start = ~reset & tick & (h_count == '0) & (v_count == '0);

    logic [FlagWidth-1:0] flags_now, flags_dly;

    always_comb begin
        flags_now              = '0;
        flags_now[FlagVisible] = h_visible & v_visible;
        flags_now[FlagHsync]   = h_sync_active;
        flags_now[FlagVsync]   = v_sync_active;
`ifdef VGA3_INTERFACE_BORDER_EN
        flags_now[FlagBorder]  = (h_count == '0) | (h_count == HAddrSize'(HVisibleArea - 1)) |
                                 (v_count == '0) | (v_count == VAddrSize'(VVisibleArea - 1));
`endif
    end

    // Delay the flags so they meet the pixel data the framebuffer returns
    if (FbLatency == 0) begin : g_no_delay
        assign flags_dly = flags_now;
    end else begin : g_delay
        logic [FlagWidth-1:0] pipe_q [FbLatency];

        always_ff @(posedge clock) begin
            if (reset) begin
                for (int i = 0; i < FbLatency; i++) pipe_q[i] <= '0;
            end else begin
                pipe_q[0] <= flags_now;
                for (int i = 1; i < FbLatency; i++) pipe_q[i] <= pipe_q[i-1];
            end
        end

        assign flags_dly = pipe_q[FbLatency-1];
    end

    logic [3*ColorWidth-1:0] rgb_d, rgb_q;
    logic                    hsync_q, vsync_q;

    always_comb begin
        rgb_d = '0;
        if (flags_dly[FlagVisible]) begin
            rgb_d = {vga.color_r, vga.color_g, vga.color_b};
`ifdef VGA3_INTERFACE_BORDER_EN
            if (flags_dly[FlagBorder]) rgb_d = BorderColor;
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rgb_q   <= '0;
            hsync_q <= ~HSyncPolarity;
            vsync_q <= ~VSyncPolarity;
        end else begin
            rgb_q   <= rgb_d;
            hsync_q <= flags_dly[FlagHsync] ? HSyncPolarity : ~HSyncPolarity;
            vsync_q <= flags_dly[FlagVsync] ? VSyncPolarity : ~VSyncPolarity;
        end
    end

    assign vga.vga_r     = rgb_q[3*ColorWidth-1 -: ColorWidth];
    assign vga.vga_g     = rgb_q[2*ColorWidth-1 -: ColorWidth];
    assign vga.vga_b     = rgb_q[ColorWidth-1:0];
    assign vga.vga_hsync = hsync_q;
    assign vga.vga_vsync = vsync_q;

endmodule
